mano_bus_regbank: RTL and testbench

- Parametrised successor to the basic-computer single register and common-bus mux.
- Holds NREG general registers of WIDTH bits. Each register has its own load, increment and clear controls.
- A common bus selects memory input or any register. All register loads take their value from that bus.
- Includes the sequence counter and one-hot timing decoder (T0..Tn) that drives the control unit.

---
 rtl/mano_bus_regbank_if.sv | 39 +++
 rtl/mano_bus_regbank.sv | 104 ++++++++++
 tb/tb_mano_bus_regbank.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mano_bus_regbank_if.sv
// rtl/mano_bus_regbank_if.sv - common bus, register and sequence counter signal bundle
// Optional wrap_flag signal present when REG_WRAP_FLAG_EN is defined.
interface mano_bus_regbank_if #(
    parameter int WIDTH = 16,
    parameter int NREG  = 6,
    parameter int SEL_W = 3,
    parameter int SC_W  = 4
);
    logic [SEL_W-1:0]       bus_sel;
    logic [WIDTH-1:0]       mem_in;
    logic [NREG-1:0]        ld;
    logic [NREG-1:0]        inc;
    logic [NREG-1:0]        clr;
    logic                   sc_en;
    logic                   sc_clr;
    logic [WIDTH-1:0]       bus_out;
    logic [NREG*WIDTH-1:0]  reg_q;
    logic [SC_W-1:0]        sc_q;
    logic [2**SC_W-1:0]     t_out;
`ifdef REG_WRAP_FLAG_EN
    logic [NREG-1:0]        wrap_flag;
`endif

    modport master (
        output bus_sel, mem_in, ld, inc, clr, sc_en, sc_clr,
        input  bus_out, reg_q, sc_q, t_out
`ifdef REG_WRAP_FLAG_EN
        , input wrap_flag
`endif
    );

    modport slave (
        input  bus_sel, mem_in, ld, inc, clr, sc_en, sc_clr,
        output bus_out, reg_q, sc_q, t_out
`ifdef REG_WRAP_FLAG_EN
        , output wrap_flag
`endif
    );
endinterface

// File: rtl/mano_bus_regbank.sv
// rtl/mano_bus_regbank.sv - basic-computer register bank, common bus mux, sequence counter and timing decoder
// Optional sticky per-register wrap flag when REG_WRAP_FLAG_EN is defined.
module mano_bus_regbank #(
    parameter int WIDTH = 16,
    parameter int NREG  = 6,
    parameter int SEL_W = 3,
    parameter int SC_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    mano_bus_regbank_if.slave   bus_if
);
    localparam int NT = 2**SC_W;

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [WIDTH-1:0] bus_val;
    logic [SC_W-1:0]  sc_q, sc_d;
    logic [NT-1:0]    t_q, t_d;
`ifdef REG_WRAP_FLAG_EN
    logic [NREG-1:0]  wrap_q, wrap_d;
`endif

    // Selector values above NREG have no source and read as zero.
    always_comb begin
        bus_val = '0;
        if (bus_if.bus_sel == '0) begin
            bus_val = bus_if.mem_in;
        end
        for (int k = 0; k < NREG; k++) begin
            if (bus_if.bus_sel == SEL_W'(k + 1)) begin
                bus_val = regs_q[k];
            end
        end
    end

    always_comb begin
`ifdef REG_WRAP_FLAG_EN
        wrap_d = wrap_q;
`endif
        for (int k = 0; k < NREG; k++) begin
            regs_d[k] = regs_q[k];
            if (bus_if.clr[k]) begin
                regs_d[k] = '0;
            end else if (bus_if.ld[k]) begin
                regs_d[k] = bus_val;
            end else if (bus_if.inc[k]) begin
                regs_d[k] = regs_q[k] + WIDTH'(1);
            end
`ifdef REG_WRAP_FLAG_EN
            if (bus_if.clr[k] || bus_if.ld[k]) begin
                wrap_d[k] = 1'b0;
            end else if (bus_if.inc[k] && (&regs_q[k])) begin
                wrap_d[k] = 1'b1;
            end
`endif
        end
    end

    // Timing decode is taken from the next count so t_out is a clean register output.
    always_comb begin
        sc_d = sc_q;
        if (bus_if.sc_clr) begin
            sc_d = '0;
        end else if (bus_if.sc_en) begin
            sc_d = sc_q + SC_W'(1);
        end
        t_d       = '0;
        t_d[sc_d] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                regs_q[k] <= '0;
            end
            sc_q <= '0;
            t_q  <= NT'(1);
`ifdef REG_WRAP_FLAG_EN
            wrap_q <= '0;
`endif
        end else begin
            for (int k = 0; k < NREG; k++) begin
                regs_q[k] <= regs_d[k];
            end
            sc_q <= sc_d;
            t_q  <= t_d;
`ifdef REG_WRAP_FLAG_EN
            wrap_q <= wrap_d;
`endif
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_reg_out
        assign bus_if.reg_q[g*WIDTH +: WIDTH] = regs_q[g];
    end

    assign bus_if.bus_out = bus_val;
    assign bus_if.sc_q    = sc_q;
    assign bus_if.t_out   = t_q;
`ifdef REG_WRAP_FLAG_EN
    assign bus_if.wrap_flag = wrap_q;
`endif
endmodule

// File: tb/tb_mano_bus_regbank.sv
// tb/tb_mano_bus_regbank.sv - directed self-checking bench for mano_bus_regbank
module tb_mano_bus_regbank;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mano_bus_regbank_if bif ();

    mano_bus_regbank dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bif.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] get_reg(input int k);
        return bif.reg_q[k*16 +: 16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bif.ld = '0; bif.inc = '0; bif.clr = '0;
        bif.sc_en = 1'b0; bif.sc_clr = 1'b0;
    endtask

    task automatic load_reg(input int k, input logic [15:0] v);
        bif.bus_sel = 3'd0;
        bif.mem_in  = v;
        bif.ld      = 6'(1 << k);
        tick();
        idle();
    endtask

    task automatic test_reset();
        logic [15:0] exp_t;
        exp_t = 16'h0001;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (get_reg(k) !== 16'h0000) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h expected 0000", k, get_reg(k));
            end
        end
        checks++;
        if (bif.sc_q !== 4'd0 || bif.t_out !== exp_t) begin
            errors++;
            $display("FAIL reset_sc: sc=%0d t=%h expected sc=0 t=%h", bif.sc_q, bif.t_out, exp_t);
        end
    endtask

    task automatic test_mem_load();
        bif.bus_sel = 3'd0;
        bif.mem_in  = 16'hBEEF;
        bif.ld      = 6'b000011;
        #1;
        checks++;
        if (bif.bus_out !== 16'hBEEF) begin
            errors++;
            $display("FAIL mem_bus: got %h expected beef", bif.bus_out);
        end
        tick();
        idle();
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (get_reg(k) !== ((k < 2) ? 16'hBEEF : 16'h0000)) begin
                errors++;
                $display("FAIL mem_load_reg%0d: got %h expected %h", k, get_reg(k),
                         (k < 2) ? 16'hBEEF : 16'h0000);
            end
        end
    endtask

    task automatic test_transfer();
        load_reg(2, 16'h1234);
        load_reg(3, 16'h00FF);
        bif.bus_sel = 3'd3;
        bif.ld      = 6'b001000;
        bif.inc     = 6'b000100;
        #1;
        checks++;
        if (bif.bus_out !== 16'h1234) begin
            errors++;
            $display("FAIL xfer_bus: got %h expected 1234", bif.bus_out);
        end
        tick();
        idle();
        checks++;
        if (get_reg(3) !== 16'h1234 || get_reg(2) !== 16'h1235) begin
            errors++;
            $display("FAIL xfer: reg3=%h reg2=%h expected reg3=1234 reg2=1235", get_reg(3), get_reg(2));
        end
        // source cleared while transferring: destination still gets old value
        bif.bus_sel = 3'd3;
        bif.ld      = 6'b100000;
        bif.clr     = 6'b000100;
        tick();
        idle();
        checks++;
        if (get_reg(5) !== 16'h1235 || get_reg(2) !== 16'h0000) begin
            errors++;
            $display("FAIL xfer_clr: reg5=%h reg2=%h expected reg5=1235 reg2=0000", get_reg(5), get_reg(2));
        end
    endtask

    task automatic test_priority_wrap();
        load_reg(1, 16'hFFFF);
        bif.inc = 6'b000010;
        tick();
        idle();
        checks++;
        if (get_reg(1) !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_reg1: got %h expected 0000", get_reg(1));
        end
`ifdef REG_WRAP_FLAG_EN
        checks++;
        if (bif.wrap_flag[1] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_flag_set: got %b expected 1", bif.wrap_flag[1]);
        end
`endif
        bif.bus_sel = 3'd0;
        bif.mem_in  = 16'h5555;
        bif.clr     = 6'b000010;
        bif.ld      = 6'b000010;
        bif.inc     = 6'b000010;
        tick();
        idle();
        checks++;
        if (get_reg(1) !== 16'h0000) begin
            errors++;
            $display("FAIL prio_clr: got %h expected 0000", get_reg(1));
        end
`ifdef REG_WRAP_FLAG_EN
        checks++;
        if (bif.wrap_flag[1] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_flag_clr: got %b expected 0", bif.wrap_flag[1]);
        end
`endif
        bif.ld  = 6'b000010;
        bif.inc = 6'b000010;
        tick();
        idle();
        checks++;
        if (get_reg(1) !== 16'h5555) begin
            errors++;
            $display("FAIL prio_ld: got %h expected 5555", get_reg(1));
        end
    endtask

    task automatic test_self_load();
        load_reg(3, 16'hA5A5);
        load_reg(5, 16'h0F0F);
        bif.bus_sel = 3'd4;
        bif.ld      = 6'b001000;
        tick();
        idle();
        checks++;
        if (get_reg(3) !== 16'hA5A5 || bif.bus_out !== 16'hA5A5) begin
            errors++;
            $display("FAIL self_load: reg3=%h bus=%h expected a5a5", get_reg(3), bif.bus_out);
        end
        bif.bus_sel = 3'd6;
        #1;
        checks++;
        if (bif.bus_out !== 16'h0F0F) begin
            errors++;
            $display("FAIL bus_sel6: got %h expected 0f0f", bif.bus_out);
        end
        bif.bus_sel = 3'd7;
        #1;
        checks++;
        if (bif.bus_out !== 16'h0000) begin
            errors++;
            $display("FAIL bus_sel7: got %h expected 0000", bif.bus_out);
        end
    endtask

    task automatic test_seq_counter();
        logic [3:0]  exp_sc;
        logic [15:0] exp_t;
        bif.sc_en = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            exp_sc = 4'(i % 16);
            exp_t  = 16'h0001 << exp_sc;
            checks++;
            if (bif.sc_q !== exp_sc || bif.t_out !== exp_t) begin
                errors++;
                $display("FAIL sc_step%0d: sc=%0d t=%h expected sc=%0d t=%h", i, bif.sc_q, bif.t_out, exp_sc, exp_t);
            end
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (bif.sc_q !== 4'd5 || bif.t_out !== 16'h0020) begin
            errors++;
            $display("FAIL sc_at5: sc=%0d t=%h expected sc=5 t=0020", bif.sc_q, bif.t_out);
        end
        bif.sc_clr = 1'b1;
        tick();
        bif.sc_clr = 1'b0;
        bif.sc_en  = 1'b0;
        checks++;
        if (bif.sc_q !== 4'd0 || bif.t_out !== 16'h0001) begin
            errors++;
            $display("FAIL sc_clr: sc=%0d t=%h expected sc=0 t=0001", bif.sc_q, bif.t_out);
        end
        tick();
        checks++;
        if (bif.sc_q !== 4'd0 || bif.t_out !== 16'h0001) begin
            errors++;
            $display("FAIL sc_hold: sc=%0d t=%h expected sc=0 t=0001", bif.sc_q, bif.t_out);
        end
    endtask

    task automatic test_async_reset();
        bif.sc_en = 1'b1;
        tick(); tick(); tick();
        bif.ld      = 6'b111111;
        bif.inc     = 6'b111111;
        bif.bus_sel = 3'd3;
        bif.mem_in  = 16'h7777;
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (get_reg(k) !== 16'h0000) begin
                errors++;
                $display("FAIL async_rst_reg%0d: got %h expected 0000", k, get_reg(k));
            end
        end
        checks++;
        if (bif.sc_q !== 4'd0 || bif.t_out !== 16'h0001 || bif.bus_out !== 16'h0000) begin
            errors++;
            $display("FAIL async_rst: sc=%0d t=%h bus=%h expected sc=0 t=0001 bus=0000",
                     bif.sc_q, bif.t_out, bif.bus_out);
        end
        tick();
        checks++;
        if (get_reg(0) !== 16'h0000 || bif.sc_q !== 4'd0) begin
            errors++;
            $display("FAIL rst_hold: reg0=%h sc=%0d expected 0000 and 0", get_reg(0), bif.sc_q);
        end
        idle();
        rst = 1'b0;
    endtask

    initial begin
        bif.bus_sel = '0;
        bif.mem_in  = '0;
        idle();
        #12;
        test_reset();
        rst = 1'b0;
        tick();
        test_mem_load();
        test_transfer();
        test_priority_wrap();
        test_self_load();
        test_seq_counter();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
